fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/mips_pkg.sv | 27 ++
 rtl/fetch_unit_if.sv | 38 +++
 rtl/fetch_predecode.sv | 15 +
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS opcodes, instruction field positions and fetch FSM states shared with the datapath.
package mips_pkg;

    localparam logic [5:0] OP_J  = 6'd2;
    localparam logic [5:0] OP_LW = 6'd35;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;
    localparam int JADDR_HI = 25;
    localparam int JADDR_LO = 0;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    function automatic logic [5:0] opcode(input logic [31:0] ins);
        return ins[OP_HI:OP_LO];
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - Fetch unit bus: imem read port, stall/redirect control, IF/ID register outputs.
interface fetch_unit_if #(
    parameter int IMEM_AW = 6
);
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               stall;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic [31:0]        pc;
    logic [31:0]        instr;
    logic               instr_valid;
    logic               misalign_err;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        output pc,
        output instr,
        output instr_valid,
        output misalign_err
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output stall,
        output redirect_valid,
        output redirect_pc,
        input  pc,
        input  instr,
        input  instr_valid,
        input  misalign_err
    );
endinterface

// File: rtl/fetch_predecode.sv
// rtl/fetch_predecode.sv - J-type detection and target formation; exists only with FETCH_JUMP_PREDECODE_EN.
`ifdef FETCH_JUMP_PREDECODE_EN
module fetch_predecode
    import mips_pkg::*;
(
    input  logic [3:0]  seg,
    input  logic [31:0] rdata,
    output logic        is_jump,
    output logic [31:0] target
);
    // seg is the top nibble of the sequential PC (pc_f+4), not of pc_f.
    assign is_jump = (opcode(rdata) == OP_J);
    assign target  = {seg, rdata[JADDR_HI:JADDR_LO], 2'b00};
endmodule
`endif

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Instruction fetch stage with IF/ID register; FETCH_JUMP_PREDECODE_EN enables J predecode.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    fetch_unit_if.master bus
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_f_q, pc_f_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;
    logic         err_q, err_d;
    logic [31:0]  pc_seq;
    logic         jump_hit;
    logic [31:0]  jump_target;

    assign pc_seq = pc_f_q + 32'd4;

`ifdef FETCH_JUMP_PREDECODE_EN
    fetch_predecode u_predecode (
        .seg     (pc_seq[31:28]),
        .rdata   (bus.imem_rdata),
        .is_jump (jump_hit),
        .target  (jump_target)
    );
`else
    assign jump_hit    = 1'b0;
    assign jump_target = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_f_q  <= RESET_PC;
            pc_q    <= 32'd0;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_f_q  <= pc_f_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_f_d  = pc_f_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        err_d   = err_q;
        case (state_q)
            RUN: begin
                if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) begin
                    state_d = HALT;
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                end else if (bus.redirect_valid) begin
                    // Redirect wins over stall: the wrong-path word in IF/ID is dropped.
                    pc_f_d  = bus.redirect_pc;
                    valid_d = 1'b0;
                end else if (!bus.stall) begin
                    instr_d = bus.imem_rdata;
                    pc_d    = pc_f_q;
                    valid_d = 1'b1;
                    pc_f_d  = jump_hit ? jump_target : pc_seq;
                end
            end
            HALT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = HALT;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.imem_addr    = pc_f_q[IMEM_AW+1:2];
    assign bus.pc           = pc_q;
    assign bus.instr        = instr_q;
    assign bus.instr_valid  = valid_q;
    assign bus.misalign_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - Scoreboard bench for fetch_unit: reset, stall, redirect, misalign halt, jump, wrap.
module tb_fetch_unit;

`ifdef FETCH_JUMP_PREDECODE_EN
    localparam bit JP = 1'b1;
`else
    localparam bit JP = 1'b0;
`endif

    typedef struct {
        bit          sel;
        int          id;
        logic        valid;
        logic        err;
        logic [31:0] pc;
        logic [31:0] instr;
        int          addr;
        bit          chk_pi;
    } exp_t;

    logic        clk;
    logic        rst_a;
    logic        rst_b;
    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    exp_t        sbq [$];
    int          total;
    int          bad;
    int          step_id;

    fetch_unit_if #(.IMEM_AW(6)) bus_a ();
    fetch_unit_if #(.IMEM_AW(6)) bus_b ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(6)) dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .bus   (bus_a.master)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .IMEM_AW(6)) dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .bus   (bus_b.master)
    );

    assign bus_a.imem_rdata = mem_a[bus_a.imem_addr];
    assign bus_b.imem_rdata = mem_b[bus_b.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rs, input logic st, input logic rv,
                         input logic [31:0] rpc, input logic v, input logic er,
                         input logic [31:0] p, input logic [31:0] ins, input int a,
                         input bit cpi);
        exp_t e;
        @(negedge clk);
        if (!sel) begin
            rst_a                = rs;
            bus_a.stall          = st;
            bus_a.redirect_valid = rv;
            bus_a.redirect_pc    = rpc;
        end else begin
            rst_b = rs;
        end
        step_id++;
        e.sel    = sel;
        e.id     = step_id;
        e.valid  = v;
        e.err    = er;
        e.pc     = p;
        e.instr  = ins;
        e.addr   = a;
        e.chk_pi = cpi;
        sbq.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (!e.sel) begin
                    chk($sformatf("a_valid@%0d", e.id), {31'd0, bus_a.instr_valid}, {31'd0, e.valid});
                    chk($sformatf("a_err@%0d", e.id), {31'd0, bus_a.misalign_err}, {31'd0, e.err});
                    chk($sformatf("a_addr@%0d", e.id), {26'd0, bus_a.imem_addr}, e.addr);
                    if (e.chk_pi) begin
                        chk($sformatf("a_pc@%0d", e.id), bus_a.pc, e.pc);
                        chk($sformatf("a_instr@%0d", e.id), bus_a.instr, e.instr);
                    end
                end else begin
                    chk($sformatf("b_valid@%0d", e.id), {31'd0, bus_b.instr_valid}, {31'd0, e.valid});
                    chk($sformatf("b_err@%0d", e.id), {31'd0, bus_b.misalign_err}, {31'd0, e.err});
                    chk($sformatf("b_addr@%0d", e.id), {26'd0, bus_b.imem_addr}, e.addr);
                    if (e.chk_pi) begin
                        chk($sformatf("b_pc@%0d", e.id), bus_b.pc, e.pc);
                        chk($sformatf("b_instr@%0d", e.id), bus_b.instr, e.instr);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        total   = 0;
        bad     = 0;
        step_id = 0;
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 32'h2000_0000 | i;
            mem_b[i] = 32'h3000_0000 | i;
        end
        mem_a[0] = 32'h8E93_0004;
        mem_a[1] = 32'h0000_0000;
        mem_a[2] = 32'h0800_0010;
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.stall = 1'b0;
        bus_a.redirect_valid = 1'b0;
        bus_a.redirect_pc = 32'd0;
        bus_b.stall = 1'b0;
        bus_b.redirect_valid = 1'b0;
        bus_b.redirect_pc = 32'd0;

        // reset and sequential fetch
        drive(0, 0, 0, 0, 32'h0,  0, 0, 32'h0, 32'h0, 0, 1);
        drive(0, 0, 0, 0, 32'h0,  0, 0, 32'h0, 32'h0, 0, 1);
        drive(0, 1, 0, 0, 32'h0,  1, 0, 32'h0, 32'h8E93_0004, 1, 1);
        drive(0, 1, 0, 0, 32'h0,  1, 0, 32'h4, 32'h0, 2, 1);
        // stall holds everything
        for (int k = 0; k < 3; k++)
            drive(0, 1, 1, 0, 32'h0, 1, 0, 32'h4, 32'h0, 2, 1);
        drive(0, 1, 0, 0, 32'h0,  1, 0, 32'h8, 32'h0800_0010, JP ? 16 : 3, 1);
        drive(0, 1, 0, 0, 32'h0,  1, 0, JP ? 32'h40 : 32'hC,
              JP ? mem_a[16] : mem_a[3], JP ? 17 : 4, 1);
        // redirect with simultaneous stall
        drive(0, 1, 1, 1, 32'h20, 0, 0, 32'h0, 32'h0, 8, 0);
        drive(0, 1, 0, 0, 32'h0,  1, 0, 32'h20, mem_a[8], 9, 1);
        drive(0, 1, 0, 0, 32'h0,  1, 0, 32'h24, mem_a[9], 10, 1);
        // misaligned redirect halts; later stimulus ignored
        drive(0, 1, 0, 1, 32'h22, 0, 1, 32'h0, 32'h0, 10, 0);
        drive(0, 1, 0, 1, 32'h40, 0, 1, 32'h0, 32'h0, 10, 0);
        drive(0, 1, 0, 0, 32'h0,  0, 1, 32'h0, 32'h0, 10, 0);
        drive(0, 1, 1, 0, 32'h0,  0, 1, 32'h0, 32'h0, 10, 0);
        // reset out of HALT while stalled
        drive(0, 0, 1, 0, 32'h0,  0, 0, 32'h0, 32'h0, 0, 1);
        drive(0, 1, 0, 0, 32'h0,  1, 0, 32'h0, 32'h8E93_0004, 1, 1);
        // PC wrap-around
        drive(1, 0, 0, 0, 32'h0,  0, 0, 32'h0, 32'h0, 63, 1);
        drive(1, 1, 0, 0, 32'h0,  1, 0, 32'hFFFF_FFFC, mem_b[63], 0, 1);
        drive(1, 1, 0, 0, 32'h0,  1, 0, 32'h0, mem_b[0], 1, 1);

        repeat (3) @(negedge clk);
        chk("drain", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
